// File: rtl/reg_file_clr.sv
// reg_file_clr: two-read/one-write register file with bypass, optional zero entry,
// per-entry dirty flags and a sequential bulk-clear engine.
module reg_file_clr #(
    parameter int DW      = 8,
    parameter int PW      = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_addr,
    input  logic [DW-1:0]     dat_in,
    input  logic [PW-1:0]     rd_addrA,
    input  logic [PW-1:0]     rd_addrB,
    input  logic              clr_start,
    output logic [DW-1:0]     datA_out,
    output logic [DW-1:0]     datB_out,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_err,
    output logic [2**PW-1:0]  dirty
);
    localparam int DEPTH = 2**PW;
    // State bits double as the busy/clr_done outputs, so both come straight from flops.
    typedef enum logic [1:0] {IDLE = 2'b00, CLEAR = 2'b01, DONE = 2'b10} state_t;
    state_t        r_state, w_next;
    logic [PW-1:0] r_ptr;
    logic [DW-1:0] r_core [DEPTH];
    logic [DEPTH-1:0] r_dirty;
    logic          r_wr_err;
    logic          w_we, w_fwd_a, w_fwd_b;

    assign busy     = r_state[0];
    assign clr_done = r_state[1];
    assign wr_err   = r_wr_err;
    assign dirty    = r_dirty;
    assign w_we     = wr_en && !busy && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign w_fwd_a  = (BYPASS != 0) && w_we && (wr_addr == rd_addrA);
    assign w_fwd_b  = (BYPASS != 0) && w_we && (wr_addr == rd_addrB);
    assign datA_out = ((ZERO_R0 != 0) && (rd_addrA == '0)) ? '0 : w_fwd_a ? dat_in : r_core[rd_addrA];
    assign datB_out = ((ZERO_R0 != 0) && (rd_addrB == '0)) ? '0 : w_fwd_b ? dat_in : r_core[rd_addrB];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = clr_start ? CLEAR : IDLE;
            CLEAR:   w_next = (r_ptr == PW'(DEPTH-1)) ? DONE : CLEAR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wr_err <= wr_en && busy;
            if (r_state == IDLE && clr_start)
                r_ptr <= '0;
            else if (r_state == CLEAR && r_ptr != PW'(DEPTH-1))
                r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_core[i] <= '0;
            r_dirty <= '0;
        end else if (busy) begin
            r_core[r_ptr]  <= '0;
            r_dirty[r_ptr] <= 1'b0;
        end else if (w_we) begin
            r_core[wr_addr]  <= dat_in;
            r_dirty[wr_addr] <= 1'b1;
        end
    end
endmodule
